// File: rtl/fconv_sched_if.sv
// fconv_sched_if: request/response bundle between the two issue ports and the
// shared float/int conversion scheduler. The master side is the issue logic,
// the slave side is fconv_sched.
interface fconv_sched_if;
  // Requester 0
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_op;
  logic [31:0] req0_data;

  // Requester 1
  logic        req1_valid;
  logic        req1_ready;
  logic        req1_op;
  logic [31:0] req1_data;

  // Shared response bus plus per-requester valid strobes
  logic        resp0_valid;
  logic        resp1_valid;
  logic [31:0] resp_data;
  logic        idle;

  modport master (
    output req0_valid, req0_op, req0_data,
    output req1_valid, req1_op, req1_data,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_data, idle
  );

  modport slave (
    input  req0_valid, req0_op, req0_data,
    input  req1_valid, req1_op, req1_data,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_data, idle
  );
endinterface

// File: rtl/fconv_sched.sv
// fconv_sched: round-robin scheduler sharing one float<->int converter between
// two requesters. The converter is combinational in the accept cycle and its
// result rides a LATENCY-deep shift pipeline (legal LATENCY 1..4) to the
// shared response bus. Responses have no backpressure.
//
// Optional feature macro FCONV_ITOF_EN: when defined, reqN_op = 1 selects the
// int->float path. When undefined, the itof unit is absent, reqN_op is
// ignored and every operation is float->int.
module fconv_sched #(
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  fconv_sched_if.slave  bus
);

  localparam int unsigned LAST = LATENCY - 1;

  // Float -> int, round half away from zero. Exponent 0 (zero/denormal) and
  // anything below 0.5 give 0. Huge or non-finite inputs have no defined
  // result; the left shift simply wraps into 32 bits.
  function automatic logic [31:0] ftoi(input logic [31:0] f);
    logic        sgn;
    logic [7:0]  ex;
    logic [31:0] man;
    logic [31:0] twice;
    logic [31:0] mag;
    logic [7:0]  sh;
    sgn   = f[31];
    ex    = f[30:23];
    man   = {8'b0, 1'b1, f[22:0]};
    twice = '0;
    mag   = '0;
    sh    = '0;
    if (ex < 8'd126) begin
      mag = '0;
    end else if (ex < 8'd150) begin
      // Keep one fractional bit (value*2 truncated), add one half, drop it.
      sh    = 8'd149 - ex;
      twice = man >> sh;
      mag   = (twice + 32'd1) >> 1;
    end else begin
      sh  = ex - 8'd150;
      mag = man << sh;
    end
    return sgn ? (~mag + 32'd1) : mag;
  endfunction

`ifdef FCONV_ITOF_EN
  // Int -> float with round-to-nearest-even. The magnitude is normalised so
  // its leading one sits at bit 31; bits 7..0 then hold guard and sticky.
  function automatic logic [31:0] itof(input logic [31:0] x);
    logic        sgn;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  msb;
    logic        rup;
    logic [24:0] rnd;
    logic [7:0]  ex;
    logic [22:0] frac;
    logic [31:0] res;
    sgn = x[31];
    mag = sgn ? (~x + 32'd1) : x;
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm = mag << (5'd31 - msb);
    rup  = norm[7] & ((|norm[6:0]) | norm[8]);
    rnd  = {1'b0, norm[31:8]} + {24'b0, rup};
    ex   = 8'd127 + {3'b0, msb} + {7'b0, rnd[24]};
    frac = rnd[24] ? rnd[23:1] : rnd[22:0];
    res  = {sgn, ex, frac};
    if (mag == 32'd0) res = '0;
    return res;
  endfunction
`endif

  logic        grant0;
  logic        grant1;
  logic        acceptValid;
  logic        acceptId;
  logic [31:0] selData;
  logic [31:0] convResult;
  logic        lastPtr_q;
  logic        lastPtr_d;

  logic [LATENCY-1:0] stageValid_q;
  logic [LATENCY-1:0] stageValid_d;
  logic [LATENCY-1:0] stageId_q;
  logic [LATENCY-1:0] stageId_d;
  logic [31:0]        stageData_q [LATENCY];
  logic [31:0]        stageData_d [LATENCY];

  // Round-robin grant: a lone requester always wins, on contention the one
  // that was not granted last wins. Nothing is granted while reset is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = lastPtr_q;
        grant1 = !lastPtr_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign acceptValid    = grant0 | grant1;
  assign acceptId       = grant1;

  // The pointer only moves when a grant happens; dropped requests leave it.
  always_comb begin
    lastPtr_d = lastPtr_q;
    if (grant1) begin
      lastPtr_d = 1'b1;
    end else if (grant0) begin
      lastPtr_d = 1'b0;
    end
  end

  assign selData = grant1 ? bus.req1_data : bus.req0_data;

`ifdef FCONV_ITOF_EN
  logic selOp;
  assign selOp = grant1 ? bus.req1_op : bus.req0_op;

  // Convert the granted operand in the accept cycle, op selects direction.
  always_comb begin
    convResult = selOp ? itof(selData) : ftoi(selData);
  end
`else
  logic unusedOps;
  assign unusedOps = bus.req0_op ^ bus.req1_op;

  // Convert the granted operand in the accept cycle; float->int only.
  always_comb begin
    convResult = ftoi(selData);
  end
`endif

  // Next-state for the shift pipeline: stage 0 takes the accepted result,
  // every later stage takes its predecessor.
  always_comb begin
    stageValid_d   = '0;
    stageId_d      = '0;
    stageValid_d[0] = acceptValid;
    stageId_d[0]    = acceptId;
    stageData_d[0]  = convResult;
    for (int i = 1; i < LATENCY; i++) begin
      stageValid_d[i] = stageValid_q[i-1];
      stageId_d[i]    = stageId_q[i-1];
      stageData_d[i]  = stageData_q[i-1];
    end
  end

  // Shift every cycle. The last stage only loads data on a valid so the
  // response bus holds its previous value between responses. Reset discards
  // everything in flight and hands the first contention to requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastPtr_q    <= 1'b1;
      stageValid_q <= '0;
      stageId_q    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stageData_q[i] <= '0;
      end
    end else begin
      lastPtr_q    <= lastPtr_d;
      stageValid_q <= stageValid_d;
      stageId_q    <= stageId_d;
      for (int i = 0; i < LATENCY; i++) begin
        if ((i != LAST) || stageValid_d[i]) begin
          stageData_q[i] <= stageData_d[i];
        end
      end
    end
  end

  assign bus.resp0_valid = stageValid_q[LAST] & ~stageId_q[LAST];
  assign bus.resp1_valid = stageValid_q[LAST] &  stageId_q[LAST];
  assign bus.resp_data   = stageData_q[LAST];
  assign bus.idle        = !bus.req0_valid && !bus.req1_valid && !(|stageValid_q);

endmodule

// File: tb/tb_fconv_sched.sv
// tb_fconv_sched: directed bench for fconv_sched. A table of single
// conversions is applied one at a time, followed by hand-written sequences
// for contention, back-to-back issue and reset while operations are in flight.
module tb_fconv_sched;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;

  fconv_sched_if bus ();

  fconv_sched #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edge is the active edge.
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic        op;
    logic [31:0] data;
    logic [31:0] expData;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    bus.req0_valid = 1'b0;
    bus.req0_op    = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_op    = 1'b0;
    bus.req1_data  = '0;
  endtask

  task automatic applyStimulus(input logic id, input logic op, input logic [31:0] data);
    if (id) begin
      bus.req1_valid = 1'b1;
      bus.req1_op    = op;
      bus.req1_data  = data;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_op    = op;
      bus.req0_data  = data;
    end
  endtask

  // One operation on one requester; checks grant, latency, response id/data.
  task automatic runVector(input int idx, input vec_t v);
    int          lat;
    int          pulses;
    logic        gotId;
    logic [31:0] gotData;
    lat     = 0;
    pulses  = 0;
    gotId   = 1'b0;
    gotData = '0;
    @(posedge clk); #1;
    applyStimulus(v.id, v.op, v.data);
    @(negedge clk);
    checkOutput($sformatf("v%0d own ready", idx),
                32'(v.id ? bus.req1_ready : bus.req0_ready), 32'd1);
    checkOutput($sformatf("v%0d other ready", idx),
                32'(v.id ? bus.req0_ready : bus.req1_ready), 32'd0);
    checkOutput($sformatf("v%0d idle busy", idx), 32'(bus.idle), 32'd0);
    @(posedge clk); #1;
    clearInputs();
    for (int n = 1; n <= LAT + 2; n++) begin
      @(negedge clk);
      if (bus.resp0_valid || bus.resp1_valid) begin
        pulses++;
        if (lat == 0) begin
          lat     = n;
          gotId   = bus.resp1_valid;
          gotData = bus.resp_data;
        end
      end
    end
    checkOutput($sformatf("v%0d latency", idx), 32'(lat), 32'(LAT));
    checkOutput($sformatf("v%0d pulses", idx), 32'(pulses), 32'd1);
    checkOutput($sformatf("v%0d resp id", idx), 32'(gotId), 32'(v.id));
    checkOutput($sformatf("v%0d resp data", idx), gotData, v.expData);
  endtask

  // Global guard so the run always ends even if a wait goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    logic [31:0] b2b [5];
    int          pulses;
    logic        exp0;

    vecs[0]  = '{1'b0, 1'b0, 32'h40200000, 32'h00000003};
    vecs[1]  = '{1'b1, 1'b0, 32'hC0200000, 32'hFFFFFFFD};
    vecs[2]  = '{1'b0, 1'b0, 32'h3EFFFFFF, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b0, 32'h00400000, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b0, 32'h3F000000, 32'h00000001};
    vecs[5]  = '{1'b1, 1'b0, 32'hBFC00000, 32'hFFFFFFFE};
    vecs[6]  = '{1'b0, 1'b0, 32'h40100000, 32'h00000002};
    vecs[7]  = '{1'b1, 1'b0, 32'h4B800001, 32'h01000002};
    vecs[8]  = '{1'b0, 1'b0, 32'hC2F60000, 32'hFFFFFF85};
    vecs[9]  = '{1'b1, 1'b0, 32'h4EFFFFFF, 32'h7FFFFF80};
    vecs[10] = '{1'b0, 1'b0, 32'h3F7FFFFF, 32'h00000001};
    vecs[11] = '{1'b1, 1'b0, 32'h40600000, 32'h00000004};
`ifdef FCONV_ITOF_EN
    vecs[12] = '{1'b0, 1'b1, 32'h00000007, 32'h40E00000};
`else
    vecs[12] = '{1'b0, 1'b1, 32'h00000007, 32'h00000000};
`endif

    b2b[0] = 32'h3F800000;
    b2b[1] = 32'h40000000;
    b2b[2] = 32'h40400000;
    b2b[3] = 32'h40800000;
    b2b[4] = 32'h40A00000;

    // Reset with both requesters asking: nothing may be granted.
    rst = 1'b1;
    clearInputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("rst ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    clearInputs();
    @(negedge clk);
    checkOutput("rst resp0_valid", 32'(bus.resp0_valid), 32'd0);
    checkOutput("rst resp1_valid", 32'(bus.resp1_valid), 32'd0);
    checkOutput("rst resp_data", bus.resp_data, 32'd0);
    checkOutput("rst idle", 32'(bus.idle), 32'd1);

    // Contention right after reset: grants 0,1,0,1,0,1, responses in order.
    $display("[TB] contention after reset");
    @(posedge clk); #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 32'h3F800000;
    bus.req1_data  = 32'h40000000;
    for (int k = 0; k < 6 + LAT; k++) begin
      @(negedge clk);
      if (k < 6) begin
        checkOutput($sformatf("cont grant0 k%0d", k), 32'(bus.req0_ready), 32'((k % 2) == 0));
        checkOutput($sformatf("cont grant1 k%0d", k), 32'(bus.req1_ready), 32'((k % 2) == 1));
      end
      if (k >= LAT) begin
        exp0 = ((k - LAT) % 2) == 0;
        checkOutput($sformatf("cont resp0 k%0d", k), 32'(bus.resp0_valid), 32'(exp0));
        checkOutput($sformatf("cont resp1 k%0d", k), 32'(bus.resp1_valid), 32'(!exp0));
        checkOutput($sformatf("cont data k%0d", k), bus.resp_data, exp0 ? 32'd1 : 32'd2);
      end else begin
        checkOutput($sformatf("cont early k%0d", k),
                    32'(bus.resp0_valid | bus.resp1_valid), 32'd0);
      end
      @(posedge clk); #1;
      if (k == 5) clearInputs();
    end

    // Table of single conversions.
    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      runVector(i, vecs[i]);
    end

    // Back-to-back on requester 0: no bubbles, responses 1..5 consecutively.
    $display("[TB] back-to-back requester 0");
    @(posedge clk); #1;
    for (int k = 0; k < 5 + LAT; k++) begin
      if (k < 5) begin
        bus.req0_valid = 1'b1;
        bus.req0_data  = b2b[k];
      end else begin
        clearInputs();
      end
      @(negedge clk);
      if (k < 5) begin
        checkOutput($sformatf("b2b ready k%0d", k), 32'(bus.req0_ready), 32'd1);
      end
      if (k >= LAT) begin
        checkOutput($sformatf("b2b resp0 k%0d", k), 32'(bus.resp0_valid), 32'd1);
        checkOutput($sformatf("b2b data k%0d", k), bus.resp_data, 32'(k - LAT + 1));
      end else begin
        checkOutput($sformatf("b2b early k%0d", k), 32'(bus.resp0_valid), 32'd0);
      end
      @(posedge clk); #1;
    end
    clearInputs();

    // Reset while an operation is in flight; the pointer was left at 0.
    $display("[TB] reset mid-flight");
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 32'h3F800000);
    @(negedge clk);
    checkOutput("mid accept ready0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    checkOutput("mid rst ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("mid rst ready1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clearInputs();
    pulses = 0;
    for (int n = 1; n <= LAT + 2; n++) begin
      @(negedge clk);
      if (bus.resp0_valid || bus.resp1_valid) pulses++;
    end
    checkOutput("mid no resp", 32'(pulses), 32'd0);
    checkOutput("mid idle", 32'(bus.idle), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    checkOutput("mid first grant0", 32'(bus.req0_ready), 32'd1);
    checkOutput("mid first grant1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    clearInputs();
    for (int n = 0; n < LAT + 2; n++) begin
      @(posedge clk);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fconv_sched.md
# fconv_sched

Round-robin scheduler that shares one float/int conversion datapath between two requesters. The datapath is the team's combinational `ftoi` unit (round half away from zero), optionally joined by `itof`. It is wrapped in a LATENCY-deep result pipeline. The block sits between the integer/FP issue logic and the FPU conversion hardware, so a single converter serves both issue ports.

## Interface
Parameters:
- LATENCY, 2, number of register stages from accept to response; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  1  0 = ftoi, 1 = itof.
- req0_data  in  32  operand: IEEE-754 single for ftoi, two's-complement int for itof.
- req1_valid, req1_ready, req1_op, req1_data: same as requester 0, for requester 1.
- resp0_valid  out  1  response for requester 0 on resp_data this cycle.
- resp1_valid  out  1  response for requester 1 on resp_data this cycle.
- resp_data  out  32  conversion result.
- idle  out  1  no operation in flight and no request pending.

## Operation
- A handshake completes when reqN_valid and reqN_ready are both high in the same cycle.
- No backpressure exists on responses. A requester must consume each respN_valid pulse in the cycle it is asserted.
- Arbitration is round-robin with a 1-bit pointer `last`, holding the id of the last granted requester.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester with id != `last` is granted.
  - A grant updates `last` to the granted id.
- reqN_ready = grantN. It is combinational from both valids and `last`, and depends on no other input.
- At most one grant per cycle. The block accepts one operation every cycle, with no bubbles.
- The granted operand/op is converted combinationally in the accept cycle.
  - ftoi: result = round-half-away-from-zero of the float, truncated to 32-bit two's complement.
  - itof: result = nearest-even rounding of the int to single.
- The converted result enters stage 1 with {valid, id}. Stages shift every cycle, unconditionally.
- The final stage drives resp_data and respN_valid, where N = the stage's id.
- resp_data is held at its last value when no response is valid. Verification checks it only when a respN_valid is high.
- ftoi inputs with exponent 0 (zero/denormal) produce 0.
- ftoi behaviour for exponent 255 or |x| ≥ 2^31 is unspecified and is excluded from checking.
- idle = !req0_valid && !req1_valid && no stage valid.

## Timing
- Response latency is exactly LATENCY cycles. An operation accepted at edge t raises respN_valid during the cycle after edge t+LATENCY-1.
- Throughput: 1 operation per cycle, aggregate over both requesters.
- Reset, while rst is high and at the first edge after it:
  - all stage valids are cleared and `last` = 1, so requester 0 wins the first contention;
  - resp0_valid = resp1_valid = 0 and resp_data = 0;
  - req0_ready = req1_ready = 0 while rst is high;
  - idle follows its equation with stages empty.
- Reset mid-operation: in-flight operations are discarded and never produce a response. Requests presented in the rst cycle are not accepted.
- Simultaneous accept and response in the same cycle is normal pipelined operation. No hazard exists.
- A requester dropping valid without a handshake is legal. The pointer changes only on a grant.

## Configuration
- FCONV_ITOF_EN defined: reqN_op = 1 selects itof.
- FCONV_ITOF_EN undefined:
  - the itof unit is not instantiated;
  - reqN_op is ignored and every operation is ftoi;
  - ports stay unchanged.

## Test plan
- Single ftoi: req0 {op 0, data 0x40200000 (2.5)} for one cycle -> req0_ready = 1 that cycle; resp0_valid high exactly LATENCY cycles later with resp_data = 3; resp1_valid stays 0.
- Negative rounding: req1 data 0xC0200000 (-2.5) -> resp1 data 0xFFFFFFFD (-3). Data 0x3EFFFFFF (<0.5) -> 0. Data 0x00400000 (denormal) -> 0.
- Contention: both valid continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; responses return in the same order, each LATENCY cycles after its grant.
- Back-to-back single requester: req0 valid for 5 cycles with 1.0, 2.0, 3.0, 4.0, 5.0 -> req0_ready high all 5 cycles; responses 1..5 on consecutive cycles.
- Reset mid-flight: accept two operations, assert rst for 1 cycle before they complete -> no respN_valid pulses follow; idle = 1 after reset with no valids; next contention grants requester 0 first.
- With FCONV_ITOF_EN: req0 {op 1, data 7} -> resp_data 0x40E00000. Without it, the same stimulus is treated as ftoi of 7 (a denormal) -> 0.
